// File: rtl/issue_stage_pkg.sv
// rtl/issue_stage_pkg.sv - shared widths, opcodes, state and output types for the issue stage
package issue_stage_pkg;

  localparam int OP_W     = 4;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_RXOR = 4'd3,
    ALU_CMPH = 4'd4,
    ALU_SHL  = 4'd5,
    ALU_SHR  = 4'd6
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] dest;
    logic              dest_en;
  } issue_out_t;

  // True when this cycle's writeback targets a real (nonzero) register equal to addr
  function automatic logic wb_hits(input logic wb_en, input logic [ADDR_W-1:0] wb_addr,
                                   input logic [ADDR_W-1:0] addr);
    return wb_en && (wb_addr != '0) && (wb_addr == addr);
  endfunction

endpackage

// File: rtl/issue_stage_reg_file.sv
// rtl/issue_stage_reg_file.sv - 8x8 register file, two read ports, one write port, write bypass
module reg_file
  import issue_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] ra_addr_i,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Storage: R0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read ports: R0 forced to zero, same-cycle writeback forwarded ahead of storage
  always_comb begin
    ra_data_o = regs_q[ra_addr_i];
    rb_data_o = regs_q[rb_addr_i];
    if (ra_addr_i == '0)                      ra_data_o = '0;
    else if (wb_hits(we_i, wa_i, ra_addr_i))  ra_data_o = wd_i;
    if (rb_addr_i == '0)                      rb_data_o = '0;
    else if (wb_hits(we_i, wa_i, rb_addr_i))  rb_data_o = wd_i;
  end

endmodule

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - operand read, scoreboard hazard check and registered ALU hand-off
module issue_stage
  import issue_stage_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [OP_W-1:0]   IN_OP,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [DATA_W-1:0] IMM,
  input  logic              USE_IMM,
  input  logic [ADDR_W-1:0] RD,
  input  logic              RD_EN,
  input  logic              WB_EN,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic [OP_W-1:0]   OP,
  output logic [DATA_W-1:0] INPUT_A,
  output logic [DATA_W-1:0] INPUT_B,
  output logic [ADDR_W-1:0] DEST,
  output logic              DEST_EN,
  output logic              OUT_VALID,
  input  logic              OUT_READY
);

  stage_state_e          state_q, state_d;
  issue_out_t            out_q, out_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic [DATA_W-1:0]     ra_data, rb_data;
  logic                  hazard, slot_free, accept;

  reg_file u_reg_file (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .ra_addr_i (RA),
    .rb_addr_i (RB),
    .ra_data_o (ra_data),
    .rb_data_o (rb_data),
    .we_i      (WB_EN),
    .wa_i      (WB_ADDR),
    .wd_i      (WB_DATA)
  );

  // Hazard: a source or destination still owned by an in-flight producer, unless it retires now
  always_comb begin
    hazard = 1'b0;
    if (pend_q[RA] && !wb_hits(WB_EN, WB_ADDR, RA))                 hazard = 1'b1;
    if (!USE_IMM && pend_q[RB] && !wb_hits(WB_EN, WB_ADDR, RB))     hazard = 1'b1;
    if (RD_EN && pend_q[RD] && !wb_hits(WB_EN, WB_ADDR, RD))        hazard = 1'b1;
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // FSM next state: fill on accept, drain only when consumed with nothing new arriving
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (OUT_READY && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // FSM outputs: ready never looks at IN_VALID so upstream can rely on it combinationally
  always_comb begin
    OUT_VALID = (state_q == ST_FULL);
    slot_free = !OUT_VALID || OUT_READY;
    IN_READY  = slot_free && !hazard;
    accept    = IN_VALID && IN_READY;
  end

  // Output register next value: load on accept, otherwise hold (covers stall and drain)
  always_comb begin
    out_d = out_q;
    if (accept) begin
      out_d.op      = IN_OP;
      out_d.a       = ra_data;
      out_d.b       = USE_IMM ? IMM : rb_data;
      out_d.dest    = RD;
      out_d.dest_en = RD_EN;
    end
  end

  // Scoreboard next value: clear on writeback first so a same-cycle set wins
  always_comb begin
    pend_d = pend_q;
    if (WB_EN && (WB_ADDR != '0))        pend_d[WB_ADDR] = 1'b0;
    if (accept && RD_EN && (RD != '0))   pend_d[RD]      = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Output register and scoreboard storage
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_q  <= '0;
      pend_q <= '0;
    end else begin
      out_q  <= out_d;
      pend_q <= pend_d;
    end
  end

  assign OP      = out_q.op;
  assign INPUT_A = out_q.a;
  assign INPUT_B = out_q.b;
  assign DEST    = out_q.dest;
  assign DEST_EN = out_q.dest_en;

endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - directed self-checking bench for issue_stage
module tb_issue_stage;
  import issue_stage_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET, IN_VALID, USE_IMM, RD_EN, WB_EN, OUT_READY;
  logic       IN_READY, DEST_EN, OUT_VALID;
  logic [3:0] IN_OP, OP;
  logic [2:0] RA, RB, RD, WB_ADDR, DEST;
  logic [7:0] IMM, WB_DATA, INPUT_A, INPUT_B;
  int n_cmp = 0;
  int n_bad = 0;

  issue_stage dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP),
    .RA(RA), .RB(RB), .IMM(IMM), .USE_IMM(USE_IMM), .RD(RD), .RD_EN(RD_EN),
    .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .OP(OP), .INPUT_A(INPUT_A),
    .INPUT_B(INPUT_B), .DEST(DEST), .DEST_EN(DEST_EN), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    IN_VALID = 0; IN_OP = 0; RA = 0; RB = 0; IMM = 0; USE_IMM = 0; RD = 0; RD_EN = 0;
    WB_EN = 0; WB_ADDR = 0; WB_DATA = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [7:0] imm, input logic use_imm, input logic [2:0] rd,
                       input logic rd_en);
    IN_VALID = 1; IN_OP = op; RA = ra; RB = rb; IMM = imm; USE_IMM = use_imm; RD = rd; RD_EN = rd_en;
  endtask

  task automatic test_reset();
    idle(); OUT_READY = 1; RESET = 1;
    tick(); tick();
    RESET = 0;
    #1;
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", OUT_VALID); end
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", IN_READY); end
    n_cmp++; if (dut.pend_q !== 8'h00) begin n_bad++; $display("FAIL reset_pend: got %h want 00", dut.pend_q); end
    n_cmp++; if ({OP, INPUT_A, INPUT_B, DEST, DEST_EN} !== 24'h0) begin n_bad++;
      $display("FAIL reset_outputs: got op=%h a=%h b=%h d=%h de=%b want all 0", OP, INPUT_A, INPUT_B, DEST, DEST_EN); end
    for (int r = 0; r < 8; r++) begin
      issue(ALU_ADD, 3'(r), 3'(r), 8'hAA, 1'b0, 3'd0, 1'b0);
      tick();
      n_cmp++; if (INPUT_A !== 8'h00 || INPUT_B !== 8'h00 || OUT_VALID !== 1'b1) begin n_bad++;
        $display("FAIL reset_read_r%0d: got a=%h b=%h v=%b want a=00 b=00 v=1", r, INPUT_A, INPUT_B, OUT_VALID); end
    end
    idle(); tick();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_drain: got %0b want 0", OUT_VALID); end
  endtask

  task automatic test_wb_add();
    WB_EN = 1; WB_ADDR = 3'd1; WB_DATA = 8'h05;
    tick();
    idle(); OUT_READY = 1;
    issue(ALU_ADD, 3'd1, 3'd0, 8'h03, 1'b1, 3'd0, 1'b0);
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL add_in_ready: got %0b want 1", IN_READY); end
    tick();
    n_cmp++; if (OP !== 4'd0 || INPUT_A !== 8'h05 || INPUT_B !== 8'h03 || OUT_VALID !== 1'b1) begin n_bad++;
      $display("FAIL add_result: got op=%h a=%h b=%h v=%b want op=0 a=05 b=03 v=1", OP, INPUT_A, INPUT_B, OUT_VALID); end
    idle(); tick();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL add_drain: got %0b want 0", OUT_VALID); end
  endtask

  task automatic test_raw_stall();
    OUT_READY = 1;
    issue(ALU_SUB, 3'd0, 3'd0, 8'h11, 1'b1, 3'd2, 1'b1);
    tick();
    n_cmp++; if (DEST !== 3'd2 || DEST_EN !== 1'b1 || dut.pend_q !== 8'h04) begin n_bad++;
      $display("FAIL raw_producer: got dest=%0d de=%b pend=%h want dest=2 de=1 pend=04", DEST, DEST_EN, dut.pend_q); end
    issue(ALU_XOR, 3'd2, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL raw_stall_c%0d: got in_ready=%0b want 0", c, IN_READY); end
      tick();
    end
    WB_EN = 1; WB_ADDR = 3'd2; WB_DATA = 8'h7F;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL raw_bypass_ready: got %0b want 1", IN_READY); end
    tick();
    idle();
    n_cmp++; if (INPUT_A !== 8'h7F || OP !== 4'd2 || OUT_VALID !== 1'b1) begin n_bad++;
      $display("FAIL raw_result: got a=%h op=%h v=%b want a=7f op=2 v=1", INPUT_A, OP, OUT_VALID); end
    n_cmp++; if (dut.pend_q !== 8'h00) begin n_bad++; $display("FAIL raw_pend_clear: got %h want 00", dut.pend_q); end
    tick();
  endtask

  task automatic test_backpressure();
    OUT_READY = 0;
    issue(ALU_SHL, 3'd1, 3'd0, 8'h01, 1'b1, 3'd3, 1'b1);
    tick();
    issue(ALU_SHR, 3'd2, 3'd0, 8'h02, 1'b1, 3'd4, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OP !== 4'd5 || INPUT_A !== 8'h05 ||
                   INPUT_B !== 8'h01 || DEST !== 3'd3 || DEST_EN !== 1'b1) begin n_bad++;
        $display("FAIL bp_hold_c%0d: got rdy=%b v=%b op=%h a=%h b=%h d=%0d want rdy=0 v=1 op=5 a=05 b=01 d=3",
                 c, IN_READY, OUT_VALID, OP, INPUT_A, INPUT_B, DEST); end
      tick();
    end
    OUT_READY = 1;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %0b want 1", IN_READY); end
    tick();
    idle();
    n_cmp++; if (OP !== 4'd6 || INPUT_A !== 8'h7F || INPUT_B !== 8'h02 || DEST !== 3'd4 || OUT_VALID !== 1'b1) begin n_bad++;
      $display("FAIL bp_second: got op=%h a=%h b=%h d=%0d v=%b want op=6 a=7f b=02 d=4 v=1", OP, INPUT_A, INPUT_B, DEST, OUT_VALID); end
    n_cmp++; if (dut.pend_q !== 8'h18) begin n_bad++; $display("FAIL bp_pend: got %h want 18", dut.pend_q); end
    tick();
    WB_EN = 1; WB_ADDR = 3'd3; WB_DATA = 8'h33; tick();
    WB_ADDR = 3'd4; WB_DATA = 8'h44; tick();
    idle();
  endtask

  task automatic test_r0();
    OUT_READY = 1;
    WB_EN = 1; WB_ADDR = 3'd0; WB_DATA = 8'hFF;
    tick();
    idle();
    issue(ALU_RXOR, 3'd0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL r0_ready_first: got %0b want 1", IN_READY); end
    tick();
    n_cmp++; if (INPUT_A !== 8'h00 || INPUT_B !== 8'h00 || dut.pend_q !== 8'h00) begin n_bad++;
      $display("FAIL r0_read: got a=%h b=%h pend=%h want 00 00 00", INPUT_A, INPUT_B, dut.pend_q); end
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL r0_ready_second: got %0b want 1", IN_READY); end
    tick();
    idle(); tick();
  endtask

  task automatic test_set_wins();
    OUT_READY = 1;
    WB_EN = 1; WB_ADDR = 3'd6; WB_DATA = 8'h66;
    issue(ALU_ADD, 3'd0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1);
    tick();
    idle();
    n_cmp++; if (dut.pend_q !== 8'h40) begin n_bad++; $display("FAIL set_wins_pend: got %h want 40", dut.pend_q); end
    WB_EN = 1; WB_ADDR = 3'd6; WB_DATA = 8'h67;
    issue(ALU_ADD, 3'd6, 3'd3, 8'h00, 1'b0, 3'd0, 1'b0);
    tick();
    idle();
    n_cmp++; if (INPUT_A !== 8'h67 || INPUT_B !== 8'h33 || dut.pend_q !== 8'h00) begin n_bad++;
      $display("FAIL set_wins_read: got a=%h b=%h pend=%h want a=67 b=33 pend=00", INPUT_A, INPUT_B, dut.pend_q); end
    tick();
  endtask

  task automatic test_async_reset();
    OUT_READY = 0;
    issue(ALU_CMPH, 3'd1, 3'd0, 8'h09, 1'b1, 3'd5, 1'b1);
    tick();
    issue(ALU_ADD, 3'd5, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0);
    tick();
    #2 RESET = 1;
    #1;
    n_cmp++; if ({OUT_VALID, OP, INPUT_A, INPUT_B, DEST, DEST_EN} !== 25'h0) begin n_bad++;
      $display("FAIL areset_outputs: got v=%b op=%h a=%h b=%h d=%0d de=%b want all 0", OUT_VALID, OP, INPUT_A, INPUT_B, DEST, DEST_EN); end
    n_cmp++; if (dut.pend_q !== 8'h00) begin n_bad++; $display("FAIL areset_pend: got %h want 00", dut.pend_q); end
    #1 RESET = 0;
    idle(); OUT_READY = 1;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready: got %0b want 1", IN_READY); end
    issue(ALU_ADD, 3'd1, 3'd2, 8'h00, 1'b0, 3'd0, 1'b0);
    tick();
    idle();
    n_cmp++; if (INPUT_A !== 8'h00 || INPUT_B !== 8'h00 || OUT_VALID !== 1'b1) begin n_bad++;
      $display("FAIL areset_regs: got a=%h b=%h v=%b want 00 00 1", INPUT_A, INPUT_B, OUT_VALID); end
    tick();
  endtask

  initial begin
    idle(); OUT_READY = 1; RESET = 1;
    test_reset();
    test_wb_add();
    test_raw_stall();
    test_backpressure();
    test_r0();
    test_set_wins();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
